// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//   Packs RATIO consecutive narrow valid/ready words into one wide word.
//   The first narrow word lands in the least significant slot of the wide word.
//   Storage is split into an accumulator, which collects the narrow words, and
//   an output register, which holds the finished wide word. Because of this
//   split the input keeps streaming while a finished word waits to be taken,
//   so there are no bubbles.
//   A level flush request sends out the partial accumulator, with its unused
//   slots zeroed and with its fill count. It then pulses flush_done_o.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   stream_s_*          narrow slave port (data/valid in, ready out)
//   stream_m_*          wide master port (data/count/valid out, ready in)
//   flush_i             level request: emit partial accumulator
//   flush_done_o        one-cycle pulse when the flush has been serviced
// -----------------------------------------------------------------------------
module stream_upsizer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  localparam int CW   = $clog2(RATIO + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       stream_s_data_i,
  input  logic                   stream_s_valid_i,
  output logic                   stream_s_ready_o,
  output logic [WIDTH*RATIO-1:0] stream_m_data_o,
  output logic [CW-1:0]          stream_m_count_o,
  output logic                   stream_m_valid_o,
  input  logic                   stream_m_ready_i,
  input  logic                   flush_i,
  output logic                   flush_done_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

  logic [WIDTH*RATIO-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0] data_q, data_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic                   slot_free;
  logic                   s_ready;
  logic                   s_accept;
  logic [WIDTH*RATIO-1:0] acc_ins;

  // The output register can take a new word this cycle if it is empty
  // or if its current word is being taken.
  assign slot_free = !valid_q || stream_m_ready_i;

  // Only the word that completes a wide word needs a free output slot.
  // Any earlier word only fills the accumulator.
  assign s_ready  = !flush_i && ((cnt_q != LAST_IDX) || slot_free);
  assign s_accept = stream_s_valid_i && s_ready;

  // Accumulator with the incoming word placed in slot cnt_q.
  always_comb begin
    acc_ins = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        acc_ins[k*WIDTH +: WIDTH] = stream_s_data_i;
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    // Output taken: the slot empties unless something reloads it below.
    if (valid_q && stream_m_ready_i) begin
      valid_d = 1'b0;
    end

    if (flush_i) begin
      if (cnt_q == '0) begin
        done_d = 1'b1;
      end else if (slot_free) begin
        // Unused slots of the accumulator are already zero: it is cleared on
        // every hand-off and filled from the bottom.
        data_d  = acc_q;
        count_d = cnt_q;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    end else if (s_accept) begin
      if (cnt_q == LAST_IDX) begin
        data_d  = acc_ins;
        count_d = FULL_CNT;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_ins;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign stream_s_ready_o = s_ready;
  assign stream_m_data_o  = data_q;
  assign stream_m_count_o = count_q;
  assign stream_m_valid_o = valid_q;
  assign flush_done_o     = done_q;

endmodule

// File: tb/tb_stream_upsizer.sv
module tb_stream_upsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = $clog2(R + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W*R-1:0] m_data;
  logic [CW-1:0] m_count;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          flush_done;

  int total = 0;
  int bad   = 0;
  int rx_words = 0;
  bit sink_random = 1'b0;

  typedef struct packed {
    logic [W*R-1:0] data;
    logic [CW-1:0]  count;
  } exp_t;
  exp_t exp_q[$];

  logic [W*R-1:0] model_acc = '0;
  int             model_cnt = 0;

  stream_upsizer #(.WIDTH(W), .RATIO(R)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream_s_data_i  (s_data),
    .stream_s_valid_i (s_valid),
    .stream_s_ready_o (s_ready),
    .stream_m_data_o  (m_data),
    .stream_m_count_o (m_count),
    .stream_m_valid_o (m_valid),
    .stream_m_ready_i (m_ready),
    .flush_i          (flush),
    .flush_done_o     (flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Bench model: pack accepted words, first word into the LSBs.
  task automatic model_push(input logic [W-1:0] w);
    model_acc[model_cnt*W +: W] = w;
    model_cnt++;
    if (model_cnt == R) begin
      exp_q.push_back('{data: model_acc, count: CW'(R)});
      model_acc = '0;
      model_cnt = 0;
    end
  endtask

  task automatic model_flush();
    if (model_cnt != 0) begin
      exp_q.push_back('{data: model_acc, count: CW'(model_cnt)});
    end
    model_acc = '0;
    model_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has been accepted.
  task automatic send(input logic [W-1:0] w, output int cycles);
    bit got = 1'b0;
    cycles  = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!got) begin
      @(negedge clk);
      if (s_ready) got = 1'b1;
      @(posedge clk); #1;
      cycles++;
      if (!got && cycles > 300) begin
        total++; bad++;
        $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", w, cycles);
        break;
      end
    end
    s_valid = 1'b0;
    if (got) model_push(w);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Random sink ready (about 30%) while enabled.
  always @(posedge clk) begin
    #1;
    if (sink_random) m_ready = ($urandom_range(9) < 3);
  end

  // Monitor: the handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      rx_words++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got data=0x%0h count=%0d with empty scoreboard", m_data, m_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (m_data !== e.data || m_count !== e.count) begin
          bad++;
          $display("FAIL mon_word: got data=0x%0h count=%0d expected data=0x%0h count=%0d",
                   m_data, m_count, e.data, e.count);
        end else begin
          $display("ok   mon_word: data=0x%0h count=%0d", m_data, m_count);
        end
      end
    end
  end

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    int rx0;

    // Reset state
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: back-to-back 01..08, sink always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), cyc);
      check("t1_accept_cycles", 64'(cyc), 64'd1);
      if (i == 4 || i == 8) begin
        check("t1_latency_valid", 64'(m_valid), 64'd1);
        check("t1_data", 64'(m_data), (i == 4) ? 64'h04030201 : 64'h08070605);
        check("t1_count", 64'(m_count), 64'd4);
      end
    end
    drain("t1_drain");

    // 2: random source (0.5) and random sink (0.3), 1000 words
    rx0 = rx_words;
    sink_random = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1) == 0) step();
      send(8'(i * 7 + 3), cyc);
    end
    sink_random = 1'b0;
    step();
    m_ready = 1'b1;
    drain("t2_drain");
    check("t2_word_count", 64'(rx_words - rx0), 64'd250);

    // 3: sink held low after first wide word
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(8'h10 + i), cyc);
    check("t3_m_valid_held", 64'(m_valid), 64'd1);
    check("t3_data_held", 64'(m_data), 64'h13121110);
    s_data = 8'h17;
    s_valid = 1'b1;
    @(negedge clk);
    check("t3_s_ready_low", 64'(s_ready), 64'd0);
    step();
    m_ready = 1'b1;
    @(negedge clk);
    check("t3_s_ready_release", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    model_push(8'h17);
    check("t3_valid_stays", 64'(m_valid), 64'd1);
    check("t3_new_data", 64'(m_data), 64'h17161514);
    drain("t3_drain");

    // 4: partial flush of AA,BB
    send(8'hAA, cyc);
    send(8'hBB, cyc);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hCC;
    model_flush();
    @(negedge clk);
    check("t4_s_ready_flush", 64'(s_ready), 64'd0);
    step();
    s_valid = 1'b0;
    check("t4_flush_done", 64'(flush_done), 64'd1);
    check("t4_m_valid", 64'(m_valid), 64'd1);
    check("t4_data", 64'(m_data), 64'h0000BBAA);
    check("t4_count", 64'(m_count), 64'd2);
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (flush_done) pulses++;
    end
    check("t4_done_pulses_after", 64'(pulses), 64'd0);
    drain("t4_drain");

    // 5: flush with empty accumulator
    rx0 = rx_words;
    flush = 1'b1;
    @(negedge clk);
    check("t5_done_not_early", 64'(flush_done), 64'd0);
    step();
    flush = 1'b0;
    check("t5_flush_done", 64'(flush_done), 64'd1);
    check("t5_no_m_valid", 64'(m_valid), 64'd0);
    step();
    check("t5_done_one_cycle", 64'(flush_done), 64'd0);
    check("t5_no_output_word", 64'(rx_words - rx0), 64'd0);

    // 6: reset with a pending wide word and a partial accumulator
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'h20 + i), cyc);
    check("t6_pre_valid", 64'(m_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 64'(m_valid), 64'd0);
    check("t6_rst_m_data", 64'(m_data), 64'd0);
    check("t6_rst_m_count", 64'(m_count), 64'd0);
    exp_q.delete();
    model_acc = '0;
    model_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), cyc);
    check("t6_post_data", 64'(m_data), 64'h34333231);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
